// File: rtl/temp_conv_ctrl.sv
// Sequencing controller for the Celsius/Fahrenheit converter: accepts a sample, drives the
// external converter, then turns the x10 result into sign plus four BCD digits for display.
module temp_conv_ctrl #(
   parameter int FRAC_BITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               smp_valid,
   input  logic signed [12:0] smp_tc,
   output logic               smp_ready,
   input  logic               unit_btn,
   output logic               unit,
   output logic signed [12:0] cv_tc,
   output logic               cv_cf,
   input  logic signed [17:0] cv_tx10,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_neg,
   output logic [15:0]        out_bcd,
   output logic               out_unit
);

   typedef enum logic [2:0] {IDLE, CONV, ABS, BCD, DONE} state_t;

   state_t             state_q;
   logic signed [12:0] cv_tc_q;
   logic               cv_cf_q;
   logic signed [17:0] result_q;
   logic               sign_q;
   logic               mag_nz_q;
   logic [12:0]        bin_q;
   logic [15:0]        bcd_q;
   logic [3:0]         cnt_q;
   logic               out_valid_q;
   logic               out_neg_q;
   logic               out_unit_q;
   logic [15:0]        out_bcd_q;
   logic               btn_s1_q;
   logic               btn_s2_q;
   logic               btn_prev_q;
   logic               unit_q;
   logic               unit_d;
   logic [12:0]        mag;
   logic [15:0]        bcd_adj;
   logic [28:0]        dd_d;

   // Negate at full 18-bit width, then drop the fraction; truncation is toward zero.
   assign mag = 13'(18'(result_q[17] ? -result_q : result_q) >> FRAC_BITS);

   for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                              : bcd_q[gi*4 +: 4];
   end

   assign dd_d = {bcd_adj, bin_q} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cv_tc_q     <= '0;
         cv_cf_q     <= 1'b0;
         result_q    <= '0;
         sign_q      <= 1'b0;
         mag_nz_q    <= 1'b0;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_neg_q   <= 1'b0;
         out_unit_q  <= 1'b0;
         out_bcd_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (smp_valid) begin
                  cv_tc_q <= smp_tc;
                  cv_cf_q <= unit_q;
                  state_q <= CONV;
               end
            end
            CONV: begin
               result_q <= cv_tx10;
               state_q  <= ABS;
            end
            ABS: begin
               sign_q   <= result_q[17];
               mag_nz_q <= (mag != 13'd0);
               bin_q    <= mag;
               bcd_q    <= '0;
               cnt_q    <= '0;
               state_q  <= BCD;
            end
            BCD: begin
               bcd_q <= dd_d[28:13];
               bin_q <= dd_d[12:0];
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd12) begin
                  out_bcd_q   <= dd_d[28:13];
                  out_unit_q  <= cv_cf_q;
                  // A magnitude that truncates to zero is reported as +0.
                  out_neg_q   <= sign_q & mag_nz_q;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A press toggles the unit on the rising edge of the synchronised button.
   assign unit_d = unit_q ^ (btn_s2_q & ~btn_prev_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         btn_prev_q <= 1'b0;
         unit_q     <= 1'b0;
      end else begin
         btn_s1_q   <= unit_btn;
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_s2_q;
         unit_q     <= unit_d;
      end
   end

   assign smp_ready = (state_q == IDLE);
   assign unit      = unit_q;
   assign cv_tc     = cv_tc_q;
   assign cv_cf     = cv_cf_q;
   assign out_valid = out_valid_q;
   assign out_neg   = out_neg_q;
   assign out_bcd   = out_bcd_q;
   assign out_unit  = out_unit_q;

endmodule

// File: tb/tb_temp_conv_ctrl.sv
// Scoreboard bench for temp_conv_ctrl with a behavioural model of the external converter.
module tb_temp_conv_ctrl;

   logic               clk;
   logic               rst_n;
   logic               smp_valid;
   logic signed [12:0] smp_tc;
   logic               smp_ready;
   logic               unit_btn;
   logic               unit;
   logic signed [12:0] cv_tc;
   logic               cv_cf;
   logic signed [17:0] cv_tx10;
   logic               out_valid;
   logic               out_ready;
   logic               out_neg;
   logic [15:0]        out_bcd;
   logic               out_unit;

   typedef struct packed {
      logic        neg;
      logic [15:0] bcd;
      logic        unit;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_unit = 1'b0;

   temp_conv_ctrl #(.FRAC_BITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .smp_valid (smp_valid),
      .smp_tc    (smp_tc),
      .smp_ready (smp_ready),
      .unit_btn  (unit_btn),
      .unit      (unit),
      .cv_tc     (cv_tc),
      .cv_cf     (cv_cf),
      .cv_tx10   (cv_tx10),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_neg   (out_neg),
      .out_bcd   (out_bcd),
      .out_unit  (out_unit)
   );

   // External converter: tenths of a degree scaled by 16 (C: tc*10, F: tc*18 + 32*10*16).
   assign cv_tx10 = cv_cf ? 18'(int'(cv_tc) * 18 + 5120) : 18'(int'(cv_tc) * 10);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic signed [12:0] tc, input logic u);
      exp_t e;
      int   t, a, m;
      t = u ? (int'(tc) * 18 + 5120) : int'(tc) * 10;
      a = (t < 0) ? -t : t;
      m = a / 16;
      e.neg  = (t < 0) && (m != 0);
      e.bcd  = {4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
      e.unit = u;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("out_without_sample", 32'(out_valid), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            $display("result bcd=%04h neg=%0d unit=%0d (exp %04h %0d %0d)",
                     out_bcd, out_neg, out_unit, mon_e.bcd, mon_e.neg, mon_e.unit);
            check("out_bcd", 32'(out_bcd), 32'(mon_e.bcd));
            check("out_neg", 32'(out_neg), 32'(mon_e.neg));
            check("out_unit", 32'(out_unit), 32'(mon_e.unit));
         end
      end
   end

   task automatic send(input logic signed [12:0] tc, input bit wait_out);
      int lat;
      bit ok;
      lat = 0;
      ok  = 0;
      @(negedge clk);
      smp_valid = 1'b1;
      smp_tc    = tc;
      for (int i = 0; i < 200; i++) begin
         if (smp_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 32'(smp_ready), 32'd1);
         smp_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 smp_valid = 1'b0;
      sb_q.push_back(model(tc, exp_unit));
      $display("send tc=%0d unit=%0d", tc, exp_unit);
      if (wait_out) begin
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
               lat = i;
               break;
            end
         end
         check("latency", 32'(lat), 32'd15);
      end
   endtask

   task automatic press();
      logic old_u, new_u;
      old_u = exp_unit;
      new_u = ~old_u;
      @(negedge clk);
      unit_btn = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("unit_before_toggle", 32'(unit), 32'(old_u));
      @(posedge clk);
      #1 check("unit_toggle", 32'(unit), 32'(new_u));
      exp_unit = new_u;
      $display("press unit=%0d", exp_unit);
      repeat (3) @(negedge clk);
      unit_btn = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || !smp_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_q", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stale;
      rst_n     = 1'b0;
      smp_valid = 1'b0;
      smp_tc    = '0;
      unit_btn  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_smp_ready", 32'(smp_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_out_neg", 32'(out_neg), 32'd0);
      check("rst_out_unit", 32'(out_unit), 32'd0);
      check("rst_unit", 32'(unit), 32'd0);
      check("rst_cv_tc", 32'(cv_tc), 32'd0);
      check("rst_cv_cf", 32'(cv_cf), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal conversions in both units, including a negative that stays positive in F.
      send(13'sd400, 1); drain();
      press();
      send(13'sd400, 1); drain();
      send(-13'sd160, 1); drain();
      press();
      send(-13'sd160, 1); drain();

      // Extremes of the input range in both units.
      press();
      send(13'sd4095, 1); drain();
      send(-13'sd4096, 1); drain();
      press();
      send(13'sd4095, 1); drain();
      send(-13'sd4096, 1); drain();

      // Tiny negative truncates to +0.
      send(-13'sd1, 1); drain();

      // Backpressure: result held, no new sample taken while waiting.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(13'sd400, 1);
      smp_valid = 1'b1;
      smp_tc    = 13'sd123;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_bcd", 32'(out_bcd), 32'(sb_q[0].bcd));
         check("bp_smp_ready", 32'(smp_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      smp_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Unit change while a result is in flight only affects the next sample.
      send(13'sd400, 0);
      repeat (3) @(negedge clk);
      press();
      drain();
      send(13'sd400, 1); drain();

      // Reset during BCD discards the in-flight sample and clears the unit.
      if (exp_unit == 1'b0) press();
      send(13'sd400, 0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_unit", 32'(unit), 32'd0);
      check("midrst_smp_ready", 32'(smp_ready), 32'd1);
      sb_q.delete();
      exp_unit = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("no_stale", 32'(stale), 32'd0);
      check("post_rst_smp_ready", 32'(smp_ready), 32'd1);
      send(-13'sd160, 1); drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
